// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // Default register-address width for the 5-stage core (32 architectural registers).
  localparam int unsigned REG_W_DEF = 5;

  // Architectural zero register; writes to it never create a dependency.
  localparam int unsigned X0_ADDR = 0;

  // Width of the remaining-bubble counter; covers LOAD_STALL up to 7.
  localparam int unsigned REM_W = 3;

  // Load-use stall FSM states.
  typedef enum logic [0:0] {
    StRun     = 1'b0,
    StLdStall = 1'b1
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: advance on inc, stick at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use stalls of configurable length,
// branch/jump flushes, data-memory freeze and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W      = REG_W_DEF,
  parameter int unsigned LOAD_STALL = 1,
  parameter bit          BR_IN_MEM  = 1'b0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_idex_memread,
  input  logic [REG_W-1:0] in_idex_rd,
  input  logic [REG_W-1:0] in_ifid_rs1,
  input  logic [REG_W-1:0] in_ifid_rs2,
  input  logic             in_ifid_uses_rs2,
  input  logic             in_branch_jal,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             ifidwrite,
  output logic             idexwrite,
  output logic             exmemwrite,
  output logic             controlsel,
  output logic             ifid_clear,
  output logic             idex_clear,
  output logic             exmem_clear,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e           state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;

  logic freeze;
  logic flush;
  logic luh;
  logic rs1_hit;
  logic rs2_hit;

  assign freeze  = mem_req & ~mem_ready;
  assign flush   = in_branch_jal;
  assign rs1_hit = (in_idex_rd == in_ifid_rs1);
  assign rs2_hit = in_ifid_uses_rs2 & (in_idex_rd == in_ifid_rs2);
  // A load targeting x0 produces nothing to wait for.
  assign luh     = in_idex_memread & (in_idex_rd != REG_W'(X0_ADDR)) & (rs1_hit | rs2_hit);

  // Event priority: reset, freeze, flush, ongoing stall, new load-use hazard.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    pcwrite     = 1'b1;
    ifidwrite   = 1'b1;
    idexwrite   = 1'b1;
    exmemwrite  = 1'b1;
    controlsel  = 1'b0;
    ifid_clear  = 1'b0;
    idex_clear  = 1'b0;
    exmem_clear = 1'b0;

    if (rst) begin
      // Hold the whole pipeline with bubbles while reset is asserted.
      pcwrite     = 1'b0;
      ifidwrite   = 1'b0;
      idexwrite   = 1'b0;
      exmemwrite  = 1'b0;
      controlsel  = 1'b1;
      ifid_clear  = 1'b1;
      idex_clear  = 1'b1;
      exmem_clear = 1'b1;
    end else if (freeze) begin
      // Whole pipeline waits on memory; flush/luh are re-evaluated afterwards.
      pcwrite    = 1'b0;
      ifidwrite  = 1'b0;
      idexwrite  = 1'b0;
      exmemwrite = 1'b0;
    end else if (flush) begin
      ifid_clear  = 1'b1;
      idex_clear  = 1'b1;
      controlsel  = 1'b1;
      exmem_clear = BR_IN_MEM;
      // Any stalled instruction is on the wrong path and is squashed.
      state_d     = StRun;
      rem_d       = '0;
    end else if (state_q == StLdStall) begin
      // The load has left EX; keep bubbling without re-checking luh.
      pcwrite    = 1'b0;
      ifidwrite  = 1'b0;
      controlsel = 1'b1;
      if (rem_q == REM_W'(1)) begin
        state_d = StRun;
        rem_d   = '0;
      end else begin
        rem_d = rem_q - REM_W'(1);
      end
    end else if (luh) begin
      pcwrite    = 1'b0;
      ifidwrite  = 1'b0;
      controlsel = 1'b1;
      if (LOAD_STALL > 1) begin
        state_d = StLdStall;
        rem_d   = REM_W'(LOAD_STALL - 1);
      end
    end
  end

  // State and remaining-bubble registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (~pcwrite & ~rst),
    .count(stall_cnt)
  );

endmodule
